// File: rtl/gpu_host_pkg.sv
// Shared definitions for the host-side pixel write port: header opcodes,
// frame-decoder states and default widths.
package gpu_host_pkg;

    localparam int ADDR_W_DEF      = 11;
    localparam int PIX_W_DEF       = 6;
    localparam int SYNC_STAGES_DEF = 2;

    localparam logic [1:0] OP_SINGLE = 2'b10;
    localparam logic [1:0] OP_BURST  = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADDR_LO = 2'd1,
        DATA    = 2'd2,
        WRITE   = 2'd3
    } wr_state_e;

    // Any opcode with the top bit set is a usable frame header.
    function automatic logic is_header(input logic [7:0] b);
        return b[7];
    endfunction

endpackage

// File: rtl/host_sync_edge.sv
// N-stage synchronizer for an asynchronous host pin, with a one-cycle pulse
// on each 0->1 transition of the synchronized level.
module host_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= (sync_q << 1) | STAGES'(d);
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/host_pixel_writer.sv
// Host byte-bus frame decoder: turns single/burst write frames strobed in on
// the parallel bus into valid/ready write requests for the pixel-block store.
module host_pixel_writer
    import gpu_host_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int PIX_W       = PIX_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        host_data,
    input  logic              host_strobe,
    input  logic              host_abort,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              host_busy,
    output logic              err_header,
    output logic              err_overrun
);

    logic                        strb_q, strb_rise;
    logic                        abort_q, abort_rise;
    logic [SYNC_STAGES-1:0][7:0] data_sync;
    logic [7:0]                  rx_byte;
    logic                        byte_ev;

    host_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_strobe (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (host_strobe),
        .q    (strb_q),
        .rise (strb_rise)
    );

    host_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_abort (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (host_abort),
        .q    (abort_q),
        .rise (abort_rise)
    );

    // The data bus is held stable across the strobe, so a plain multi-flop
    // delay keeps it aligned with the synchronized strobe edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_sync <= '0;
        end else begin
            data_sync[0] <= host_data;
            for (int i = 1; i < SYNC_STAGES; i++)
                data_sync[i] <= data_sync[i-1];
        end
    end

    assign rx_byte = data_sync[SYNC_STAGES-1];
    assign byte_ev = strb_rise & ~abort_q;

    wr_state_e         state_q, state_d;
    logic              burst_q;
    logic [ADDR_W-1:0] addr_q;
    logic [PIX_W-1:0]  data_q;
    logic              valid_q, err_hdr_q, err_ovr_q;
    logic              handshake;

    assign handshake = valid_q & wr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort_q) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (byte_ev && is_header(rx_byte)) state_d = ADDR_LO;
                ADDR_LO: if (byte_ev) state_d = DATA;
                DATA:    if (byte_ev) state_d = WRITE;
                WRITE:   if (handshake) state_d = burst_q ? DATA : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    logic ld_hdr, ld_lo, ld_data, wr_done, hdr_bad, overrun;

    // byte_ev already excludes abort; only the handshake needs explicit gating.
    always_comb begin
        ld_hdr  = 1'b0;
        ld_lo   = 1'b0;
        ld_data = 1'b0;
        wr_done = 1'b0;
        hdr_bad = 1'b0;
        overrun = 1'b0;
        case (state_q)
            IDLE: begin
                ld_hdr  = byte_ev &  is_header(rx_byte);
                hdr_bad = byte_ev & ~is_header(rx_byte);
            end
            ADDR_LO: ld_lo   = byte_ev;
            DATA:    ld_data = byte_ev;
            WRITE: begin
                wr_done = handshake & ~abort_q;
                overrun = byte_ev;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_hdr_q <= 1'b0;
            err_ovr_q <= 1'b0;
        end else if (abort_q) begin
            valid_q   <= 1'b0;
            err_hdr_q <= 1'b0;
            err_ovr_q <= 1'b0;
        end else begin
            if (ld_hdr) begin
                addr_q[ADDR_W-1:8] <= rx_byte[ADDR_W-9:0];
                burst_q            <= (rx_byte[7:6] == OP_BURST);
            end
            if (ld_lo)
                addr_q[7:0] <= rx_byte;
            if (ld_data) begin
                data_q  <= rx_byte[PIX_W-1:0];
                valid_q <= 1'b1;
            end
            if (wr_done) begin
                valid_q <= 1'b0;
                if (burst_q) addr_q <= addr_q + 1'b1;
            end
            if (hdr_bad) err_hdr_q <= 1'b1;
            if (overrun) err_ovr_q <= 1'b1;
        end
    end

    assign wr_valid    = valid_q;
    assign wr_addr     = addr_q;
    assign wr_data     = data_q;
    assign host_busy   = valid_q;
    assign err_header  = err_hdr_q;
    assign err_overrun = err_ovr_q;

    // Abort is consumed as a level; its edge and the strobe level are spare.
    logic unused_ok;
    assign unused_ok = abort_rise ^ strb_q;

endmodule

// File: tb/tb_host_pixel_writer.sv
// Randomized scoreboard bench for host_pixel_writer: a byte-level frame model
// predicts each write, a monitor pops predictions on every handshake.
module tb_host_pixel_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  host_data = 8'h00;
    logic        host_strobe = 1'b0;
    logic        host_abort = 1'b0;
    logic        wr_valid;
    logic        wr_ready = 1'b0;
    logic [10:0] wr_addr;
    logic [5:0]  wr_data;
    logic        host_busy;
    logic        err_header;
    logic        err_overrun;

    host_pixel_writer #(.ADDR_W(11), .PIX_W(6), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .host_data  (host_data),
        .host_strobe(host_strobe),
        .host_abort (host_abort),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .host_busy  (host_busy),
        .err_header (err_header),
        .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          hs_count = 0;
    int          ready_mode = 0;
    logic [16:0] exp_q[$];

    // Reference frame model: phase 0 = expecting header, 1 = low address, 2 = pixel.
    int  m_phase = 0;
    bit  m_burst = 0;
    int  m_addr = 0;
    bit  m_eh = 0;
    bit  m_eo = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        case (m_phase)
            0: begin
                if (b[7]) begin
                    m_burst = b[6];
                    m_addr  = int'(b[2:0]) * 256;
                    m_phase = 1;
                end else begin
                    m_eh = 1;
                end
            end
            1: begin
                m_addr  = (m_addr / 256) * 256 + int'(b);
                m_phase = 2;
            end
            default: begin
                exp_q.push_back({11'(m_addr), b[5:0]});
                if (m_burst) m_addr = (m_addr + 1) % 2048;
                else         m_phase = 0;
            end
        endcase
    endtask

    task automatic model_clear();
        m_phase = 0;
        m_eh    = 0;
        m_eo    = 0;
    endtask

    task automatic send_raw(input logic [7:0] b);
        @(posedge clk); #1;
        host_data   = b;
        host_strobe = 1'b1;
        repeat (4) @(posedge clk);
        #1 host_strobe = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        model_byte(b);
        send_raw(b);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!host_busy) return;
        end
        total++;
        bad++;
        $display("FAIL wait_idle host_busy stuck high at %0t", $time);
    endtask

    task automatic send_frame_byte(input logic [7:0] b);
        send_byte(b);
        wait_idle();
    endtask

    task automatic do_abort();
        @(posedge clk); #1 host_abort = 1'b1;
        repeat (5) @(posedge clk);
        #1 host_abort = 1'b0;
        repeat (5) @(posedge clk);
        model_clear();
    endtask

    task automatic check_errs(input string tag);
        @(negedge clk);
        check({tag, " err_header"}, 32'(err_header), 32'(m_eh));
        check({tag, " err_overrun"}, 32'(err_overrun), 32'(m_eo));
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       wr_ready = 1'b1;
            1:       wr_ready = 1'($urandom % 2);
            default: wr_ready = 1'b0;
        endcase
    end

    // Scoreboard monitor: a handshake completes on the following rising edge.
    always @(negedge clk) begin
        logic [16:0] e;
        if (rst_n && wr_valid && wr_ready) begin
            hs_count++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write addr=%0h data=%0h at %0t", wr_addr, wr_data, $time);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e[16:6]));
                check("wr_data", 32'(wr_data), 32'(e[5:0]));
            end
        end
    end

    initial begin
        int hs0;
        logic [7:0] hdr;
        int n;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst wr_valid", 32'(wr_valid), 0);
        check("rst wr_addr", 32'(wr_addr), 0);
        check("rst wr_data", 32'(wr_data), 0);
        check("rst host_busy", 32'(host_busy), 0);
        check("rst err_header", 32'(err_header), 0);
        check("rst err_overrun", 32'(err_overrun), 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Single write, ready tied high.
        ready_mode = 0;
        hs0 = hs_count;
        send_frame_byte(8'h85);
        send_frame_byte(8'h3C);
        send_frame_byte(8'h2A);
        check("single hs count", 32'(hs_count - hs0), 1);
        check_errs("single");

        // Burst across the top of the address space.
        send_frame_byte(8'hC7);
        send_frame_byte(8'hFE);
        send_frame_byte(8'h01);
        send_frame_byte(8'h02);
        send_frame_byte(8'h03);
        do_abort();
        check("burst drained", 32'(exp_q.size()), 0);

        // Backpressure, then an overrun byte while the write is held.
        ready_mode = 2;
        hs0 = hs_count;
        send_byte(8'h81);
        send_byte(8'h22);
        send_byte(8'h19);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp wr_valid", 32'(wr_valid), 1);
            check("bp wr_addr", 32'(wr_addr), 32'h122);
            check("bp wr_data", 32'(wr_data), 32'h19);
            check("bp host_busy", 32'(host_busy), 1);
        end
        send_raw(8'h15);
        m_eo = 1;
        check_errs("overrun");
        check("ovr wr_data", 32'(wr_data), 32'h19);
        ready_mode = 0;
        wait_idle();
        check("bp hs count", 32'(hs_count - hs0), 1);
        check("bp busy clear", 32'(host_busy), 0);

        // Bad header, then a valid frame.
        hs0 = hs_count;
        send_frame_byte(8'h40);
        check("badhdr no write", 32'(hs_count - hs0), 0);
        check_errs("badhdr");
        send_frame_byte(8'h80);
        send_frame_byte(8'h10);
        send_frame_byte(8'h3F);
        check("badhdr follow hs", 32'(hs_count - hs0), 1);

        // Abort mid-frame clears errors; next byte is parsed as a header.
        send_frame_byte(8'h85);
        send_frame_byte(8'h12);
        do_abort();
        check_errs("abort");
        hs0 = hs_count;
        send_frame_byte(8'h3F);
        check_errs("post-abort hdr");
        check("post-abort no write", 32'(hs_count - hs0), 0);
        do_abort();

        // Randomized frames with random backpressure.
        ready_mode = 1;
        for (int f = 0; f < 20; f++) begin
            if ($urandom % 4 == 0)
                send_frame_byte(8'($urandom_range(0, 127)));
            hdr = {1'b1, 1'($urandom % 2), 6'($urandom)};
            send_frame_byte(hdr);
            send_frame_byte(8'($urandom));
            n = hdr[6] ? int'($urandom_range(1, 5)) : 1;
            for (int k = 0; k < n; k++)
                send_frame_byte(8'($urandom));
            check_errs("rand");
            if (hdr[6]) do_abort();
        end
        check("rand drained", 32'(exp_q.size()), 0);

        // Asynchronous reset while a write is pending.
        ready_mode = 2;
        send_byte(8'h87);
        send_byte(8'h01);
        send_byte(8'h05);
        @(negedge clk);
        check("pre-rst wr_valid", 32'(wr_valid), 1);
        void'(exp_q.pop_back());
        #2 rst_n = 1'b0;
        #1;
        check("async rst wr_valid", 32'(wr_valid), 0);
        check("async rst host_busy", 32'(host_busy), 0);
        check("async rst wr_addr", 32'(wr_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        ready_mode = 0;
        repeat (5) @(posedge clk);
        check("final queue empty", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/host_pixel_writer.md
Name: host_pixel_writer

Overview:
- Arduino-facing write port of the GPU; the write end of the pixel-block memory that the VGA path reads by 11-bit block address.
- Receives bytes strobed in on the host parallel bus, decodes single-write and burst-write frames, and issues write requests (address + 6-bit RRGGBB) to the pixel-block store through a valid/ready handshake.
- Sits between the raw ui_in/uio_in pins and the pixel memory.

Parameters:
- ADDR_W, 11, pixel-block address width; header carries ADDR_W-8 high bits.
- PIX_W, 6, pixel data width {R[1:0],G[1:0],B[1:0]}.
- SYNC_STAGES, 2, synchronizer depth for host_strobe, host_abort and host_data.

Ports:
- clk  in  1  system clock (pixel clock domain).
- rst_n  in  1  reset; asynchronous, active-low.
- host_data  in  8  host byte bus (uio_in); stable while host_strobe high.
- host_strobe  in  1  host byte strobe, asynchronous; a rising edge delivers one byte.
- host_abort  in  1  host frame resync, asynchronous, level; while high, forces IDLE.
- wr_valid  out  1  write request to pixel store.
- wr_ready  in  1  pixel store accepts the request on a clk edge where wr_valid&wr_ready.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  PIX_W  write pixel.
- host_busy  out  1  high while a write is pending; host must not strobe.
- err_header  out  1  sticky: bad header byte seen.
- err_overrun  out  1  sticky: byte arrived while a write was pending.

Behaviour:
- Reset: wr_valid=0, wr_addr=0, wr_data=0, host_busy=0, err_header=0, err_overrun=0, state=IDLE, sync flops=0.
- Input path: host_strobe, host_abort and host_data each pass SYNC_STAGES flops. A byte event is a 0->1 transition of the synchronized strobe (one extra edge-detect flop). The byte value is the synchronized host_data on that cycle. Latency from pin edge to event is SYNC_STAGES+1 clk.
- Header byte: [7:6]=2'b10 selects single write; 2'b11 selects burst; [5:3] are ignored; [2:0] are addr[10:8].
- States:
  - IDLE: on a byte event with a valid header, latch addr_hi and the mode, then go to ADDR_LO. If [7:6] is not 1x, set err_header, drop the byte and stay in IDLE.
  - ADDR_LO: on a byte event, latch addr[7:0] and go to DATA.
  - DATA: on a byte event, set wr_data = byte[PIX_W-1:0] (byte[7:6] ignored), wr_valid=1 and host_busy=1 on the next cycle, then go to WRITE.
  - WRITE: hold wr_addr and wr_data stable while wr_valid is high. On a handshake cycle (wr_valid&wr_ready), wr_valid=0 and host_busy=0 from the next cycle.
    - Single mode: go to IDLE.
    - Burst mode: wr_addr increments by 1, wrapping 2^ADDR_W-1 -> 0, then go to DATA.
- A byte event in WRITE sets err_overrun; the byte is dropped and the state is unchanged.
- wr_ready high while wr_valid is low has no effect. wr_ready may be tied high, which gives a one-cycle WRITE.
- Synchronized host_abort high, from any state: next cycle state=IDLE and wr_valid=0; a pending write is discarded. This overrides a simultaneous handshake (the write is not counted). Abort also clears err_header and err_overrun. Byte events are ignored while abort is high.
- Burst continues indefinitely until abort. Single mode returns to IDLE automatically.
- Asynchronous reset mid-frame: all outputs return to reset values immediately.

Decomposition:
- Shared package gpu_host_pkg holds:
  - header opcodes (OP_SINGLE=2'b10, OP_BURST=2'b11);
  - the state enum (IDLE, ADDR_LO, DATA, WRITE);
  - ADDR_W and PIX_W defaults.
- One natural sub-module, host_sync_edge: an N-stage synchronizer with rising-edge pulse output. It is instantiated for the strobe and abort; host_data uses the plain synchronizer bits.

Test Plan:
- Single write: bytes 0x85, 0x3C, 0x2A with wr_ready=1 -> one wr_valid pulse, wr_addr=0x53C, wr_data=6'b101010, state returns to IDLE, no errors.
- Burst with wrap: bytes 0xC7, 0xFE, then data 0x01, 0x02, 0x03 -> writes at 0x7FE, 0x7FF, 0x000 with data 1, 2, 3. Abort -> IDLE.
- Backpressure: single frame with wr_ready=0 for 10 cycles -> wr_valid, wr_addr and wr_data stay stable and host_busy=1. Raise wr_ready -> exactly one handshake, host_busy=0 next cycle.
- Overrun: strobe a 4th byte 0x15 during backpressure -> err_overrun=1, written data still equals the 3rd byte.
- Bad header: byte 0x40 in IDLE -> err_header=1, no write. The following valid frame 0x80, 0x10, 0x3F -> write at addr 0x010 with data 0x3F.
- Abort and reset: assert abort between ADDR_LO and DATA -> IDLE, errors cleared, next 0x3F byte treated as a header (bad). Assert rst_n low during WRITE -> wr_valid=0 immediately.
